i2c_seq: RTL
============

# i2c_seq

Transaction sequencer sitting between a simple register-access requester (boot ROM loader, sensor poller) and the Wishbone-slave I2C byte master. It turns one request (7-bit device, 8-bit register, read or write) into the full chain of master register cycles: address/data loads, START, byte writes, repeated START, byte read, status checks and STOP. It reports read data and slave NAK back to the requester.

## Interface
- ACK_TIMEOUT, 65535: max clk_i cycles to wait for m_ack_i on any single bus cycle.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  request strobe, sampled only in IDLE.
- rw_i  in  1  1 = register read, 0 = register write.
- dev_i  in  7  I2C device address.
- reg_i  in  8  device register index.
- wdata_i  in  8  write data.
- busy_o  out  1  high from accepted request until done_o.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  8  read byte, valid from done_o until next accept.
- nak_o  out  1  slave NAKed; valid with done_o.
- to_o  out  1  bus ack timeout; valid with done_o.
- m_cyc_o, m_stb_o  out  1  Wishbone cycle/strobe (always equal).
- m_we_o  out  1  Wishbone write enable.
- m_adr_o  out  2  master register select.
- m_sel_o  out  4  byte lanes.
- m_dat_o  out  32  write data.
- m_dat_i  in  32  read data.
- m_ack_i  in  1  cycle acknowledge.

## Operation
- Master registers: adr 0 write: lane1 = address byte, lane0 = data byte; adr 0 read: [7:0] = received byte. Adr 1 write lane0 [1:0]: 0 START+send address byte, 1 STOP, 2 read byte, 3 write data byte. Adr 1 read: bit0 = NAK error.
- IDLE: req_i=1 latches rw_i/dev_i/reg_i/wdata_i, clears nak_o/to_o, sets busy_o, step counter = 0.
- Write micro-op list: LD({dev,0},reg) sel=4'b0011; START; STAT; WR(cmd 3, sends reg); STAT; LD data=wdata sel=4'b0001; WR; STAT; STOP.
- Read micro-op list: LD({dev,0},reg) sel=4'b0011; START; STAT; WR(reg); STAT; LD addr={dev,1} sel=4'b0010; START (repeated); STAT; RD(cmd 2); GET(adr 0 read → rdata_o=m_dat_i[7:0]); STOP.
- Command writes: adr 1, sel 4'b0001, m_dat_o = {30'h0, cmd}. Loads: adr 0, m_dat_o = {16'h0, addr, data}.
- STAT: read adr 1; if m_dat_i[0]=1 set nak_o and jump directly to STOP; else next op.
- STOP issued on every path except timeout; its ack → FIN.
- FIN: done_o=1 one cycle, busy_o=0, return to IDLE.
- FSM states: IDLE, ISSUE (cyc/stb high, waiting ack), GAP (one cycle cyc low, advance step), FIN.
- Timeout: counter cleared on entering ISSUE; if it reaches ACK_TIMEOUT without ack, drop cyc, set to_o=1, nak_o=1, go to FIN (no STOP attempted).

## Timing
- Reset values: all outputs 0, rdata_o = 8'h00, state IDLE.
- Request accepted on the clk_i edge where req_i=1 in IDLE; m_cyc_o rises the next cycle.
- Each bus cycle: cyc/stb/we/adr/sel/dat stable from assertion until the cycle m_ack_i=1 is sampled; cyc drops next cycle; minimum one idle cycle (GAP) between bus cycles.
- m_ack_i outside ISSUE ignored. req_i while busy_o=1 ignored (not queued).
- done_o asserts the cycle after GAP following the STOP ack (or the cycle after timeout).
- Zero-wait slave (ack same cycle as stb): write txn = 9 bus cycles, 2 clk_i each + accept + FIN = 20 cycles; read = 11 bus cycles, 24 cycles.
- Reset mid-transaction: cyc drops immediately (async), all state lost; the next request begins with START, which the I2C master treats as restart.

## Test plan
- Write dev 0x50 reg 0x10 data 0xA5, zero-wait model, no NAK -> bus cycles exactly: adr0 wr 0x0000A010, START, STAT, WR, STAT, adr0 wr 0x000000A5 sel 0001, WR, STAT, STOP; done_o at cycle 20, nak_o=0.
- Read dev 0x50 reg 0x10, model returns 0x3C on adr0 read -> second load addr byte 0xA1 sel 0010, rdata_o=0x3C, nak_o=0, done_o at cycle 24.
- First STAT returns 0x1 -> next bus cycle is STOP, nak_o=1 with done_o, no further WR.
- Slave withholds ack, ACK_TIMEOUT=16 -> cyc drops after 16 cycles, done_o with to_o=1, nak_o=1, no STOP cycle.
- req_i held high continuously, slave ack delayed 5 cycles -> exactly one transaction per done_o, signals stable during waits, GAP cycle present.
- rst_i pulsed mid-read during RD -> all outputs 0 within same cycle; following write request completes normally.

Source files
------------

// File: rtl/i2c_seq.sv
// Register-access sequencer: expands one read/write request into the chain of
// Wishbone cycles that drive the I2C byte master, then reports data/NAK/timeout.
module i2c_seq #(
  parameter int unsigned ACK_TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        rw_i,
  input  logic [6:0]  dev_i,
  input  logic [7:0]  reg_i,
  input  logic [7:0]  wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic        nak_o,
  output logic        to_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [1:0]  m_adr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_step;
  logic [CW-1:0] r_cnt;
  logic          r_rw;
  logic [6:0]    r_dev;
  logic [7:0]    r_reg;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rdata;
  logic          r_nak;
  logic          r_to;

  logic          w_cyc;
  logic          w_we;
  logic [1:0]    w_adr;
  logic [3:0]    w_sel;
  logic [31:0]   w_dat;
  logic          w_stat;
  logic          w_stop;
  logic          w_get;
  logic [3:0]    w_stop_step;
  logic          w_unused;

  assign w_unused    = ^m_dat_i[31:8];
  assign w_stop_step = r_rw ? 4'd10 : 4'd8;

  // Micro-op table: steps 0-4 are shared, the tail differs between read and write.
  always_comb begin
    w_we   = 1'b0;
    w_adr  = 2'd1;
    w_sel  = 4'b0001;
    w_dat  = 32'h0;
    w_stat = 1'b0;
    w_stop = 1'b0;
    w_get  = 1'b0;
    case (r_step)
      4'd0: begin
        w_we  = 1'b1;
        w_adr = 2'd0;
        w_sel = 4'b0011;
        w_dat = {16'h0, r_dev, 1'b0, r_reg};
      end
      4'd1: w_we = 1'b1;
      4'd2: w_stat = 1'b1;
      4'd3: begin
        w_we  = 1'b1;
        w_dat = 32'd3;
      end
      4'd4: w_stat = 1'b1;
      4'd5: begin
        w_we  = 1'b1;
        w_adr = 2'd0;
        if (r_rw) begin
          w_sel = 4'b0010;
          w_dat = {16'h0, r_dev, 1'b1, 8'h00};
        end else begin
          w_dat = {24'h0, r_wdata};
        end
      end
      4'd6: begin
        w_we  = 1'b1;
        w_dat = r_rw ? 32'd0 : 32'd3;
      end
      4'd7: w_stat = 1'b1;
      4'd8: begin
        w_we   = 1'b1;
        w_dat  = r_rw ? 32'd2 : 32'd1;
        w_stop = ~r_rw;
      end
      4'd9: begin
        w_adr = 2'd0;
        w_get = 1'b1;
      end
      default: begin
        w_we   = 1'b1;
        w_dat  = 32'd1;
        w_stop = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_step  <= 4'd0;
      r_cnt   <= '0;
      r_rw    <= 1'b0;
      r_dev   <= 7'h0;
      r_reg   <= 8'h0;
      r_wdata <= 8'h0;
      r_rdata <= 8'h0;
      r_nak   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_rw    <= rw_i;
            r_dev   <= dev_i;
            r_reg   <= reg_i;
            r_wdata <= wdata_i;
            r_nak   <= 1'b0;
            r_to    <= 1'b0;
            r_step  <= 4'd0;
            r_cnt   <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_ack_i) begin
            r_state <= S_GAP;
            if (w_stat && m_dat_i[0]) r_nak <= 1'b1;
            if (w_get) r_rdata <= m_dat_i[7:0];
          end else if (r_cnt == TO_LAST) begin
            r_to    <= 1'b1;
            r_nak   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          // r_nak can only have been raised by a STAT, so it means "skip to STOP".
          if (w_stop) begin
            r_state <= S_FIN;
          end else begin
            r_step  <= r_nak ? w_stop_step : r_step + 4'd1;
            r_cnt   <= '0;
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_cyc   = (r_state == S_ISSUE);
  assign m_cyc_o = w_cyc;
  assign m_stb_o = w_cyc;
  assign m_we_o  = w_cyc & w_we;
  assign m_adr_o = w_cyc ? w_adr : 2'd0;
  assign m_sel_o = w_cyc ? w_sel : 4'd0;
  assign m_dat_o = w_cyc ? w_dat : 32'h0;
  assign busy_o  = (r_state == S_ISSUE) || (r_state == S_GAP);
  assign done_o  = (r_state == S_FIN);
  assign rdata_o = r_rdata;
  assign nak_o   = r_nak;
  assign to_o    = r_to;

endmodule
